// File: rtl/uart_alu_sequencer.sv
// Packet sequencer between UART byte streams and a multi-cycle 32-bit ALU.
// Handles echo packets and add/sub/mul reductions of little-endian 32-bit operands.
module uart_alu_sequencer #(
  parameter logic [7:0] OP_ECHO = 8'hEC,
  parameter logic [7:0] OP_ADD  = 8'h10,
  parameter logic [7:0] OP_SUB  = 8'h11,
  parameter logic [7:0] OP_MUL  = 8'h12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [1:0]  alu_op_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  output logic        alu_valid_o,
  input  logic        alu_ready_i,
  input  logic        alu_done_i,
  input  logic [31:0] alu_result_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR   = 3'd1;
  localparam logic [2:0] ECHO  = 3'd2;
  localparam logic [2:0] OPND  = 3'd3;
  localparam logic [2:0] AREQ  = 3'd4;
  localparam logic [2:0] AWAIT = 3'd5;
  localparam logic [2:0] TXRES = 3'd6;
  localparam logic [2:0] DRAIN = 3'd7;

  function automatic logic [1:0] alu_code(input logic [7:0] opc);
    logic [1:0] code;
    case (opc)
      OP_ADD:  code = 2'd0;
      OP_SUB:  code = 2'd1;
      OP_MUL:  code = 2'd2;
      default: code = 2'd0;
    endcase
    return code;
  endfunction

  logic [2:0]  state_r;
  logic        run_r;
  logic        err_r;
  logic [7:0]  opcode_r;
  logic [1:0]  hdr_cnt_r;
  logic [7:0]  len_lo_r;
  logic [15:0] remain_r;
  logic [13:0] ops_left_r;
  logic        first_r;
  logic [1:0]  byte_cnt_r;
  logic [31:0] operand_r;
  logic [31:0] acc_r;
  logic [1:0]  tx_idx_r;

  logic        rx_fire_s;
  logic        tx_fire_s;
  logic [15:0] len_s;
  logic [15:0] pl_s;
  logic        short_s;
  logic        known_s;
  logic [31:0] word_s;
  logic [15:0] remain_dec_s;

  assign rx_fire_s    = rx_valid_i & rx_ready_o;
  assign tx_fire_s    = tx_valid_o & tx_ready_i;
  assign len_s        = {rx_data_i, len_lo_r};
  assign pl_s         = len_s - 16'd4;
  assign short_s      = (len_s < 16'd4);
  assign known_s      = (opcode_r == OP_ECHO) || (opcode_r == OP_ADD) ||
                        (opcode_r == OP_SUB) || (opcode_r == OP_MUL);
  assign word_s       = {rx_data_i, operand_r[23:0]};
  assign remain_dec_s = (remain_r != 16'd0) ? (remain_r - 16'd1) : 16'd0;
  assign busy_o       = (state_r != IDLE);
  assign err_o        = err_r;

  // Handshake and datapath outputs decoded from the current state.
  always_comb begin
    rx_ready_o  = 1'b0;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    alu_valid_o = 1'b0;
    alu_a_o     = 32'h0000_0000;
    alu_b_o     = 32'h0000_0000;
    alu_op_o    = 2'd0;
    case (state_r)
      IDLE, HDR, OPND: rx_ready_o = run_r;
      DRAIN:           rx_ready_o = (remain_r != 16'd0);
      ECHO: begin
        rx_ready_o = tx_ready_i;
        tx_valid_o = rx_valid_i;
        tx_data_o  = rx_data_i;
      end
      AREQ: begin
        alu_valid_o = 1'b1;
        alu_a_o     = acc_r;
        alu_b_o     = operand_r;
        alu_op_o    = alu_code(opcode_r);
      end
      TXRES: begin
        tx_valid_o = 1'b1;
        tx_data_o  = acc_r[8*tx_idx_r +: 8];
      end
      default: rx_ready_o = 1'b0;
    endcase
  end

  // Packet sequencing state machine.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= IDLE;
      run_r      <= 1'b0;
      err_r      <= 1'b0;
      opcode_r   <= 8'h00;
      hdr_cnt_r  <= 2'd0;
      len_lo_r   <= 8'h00;
      remain_r   <= 16'd0;
      ops_left_r <= 14'd0;
      first_r    <= 1'b0;
      byte_cnt_r <= 2'd0;
      operand_r  <= 32'h0000_0000;
      acc_r      <= 32'h0000_0000;
      tx_idx_r   <= 2'd0;
    end else begin
      run_r <= 1'b1;
      err_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (rx_fire_s) begin
            opcode_r  <= rx_data_i;
            hdr_cnt_r <= 2'd1;
            state_r   <= HDR;
          end
        end
        HDR: begin
          if (rx_fire_s) begin
            hdr_cnt_r <= hdr_cnt_r + 2'd1;
            if (hdr_cnt_r == 2'd2) begin
              len_lo_r <= rx_data_i;
            end
            if (hdr_cnt_r == 2'd3) begin
              byte_cnt_r <= 2'd0;
              first_r    <= 1'b1;
              ops_left_r <= pl_s[15:2];
              remain_r   <= short_s ? 16'd0 : pl_s;
              if (!known_s || short_s) begin
                err_r   <= 1'b1;
                state_r <= DRAIN;
              end else if (opcode_r == OP_ECHO) begin
                state_r <= (pl_s == 16'd0) ? IDLE : ECHO;
              end else if ((pl_s == 16'd0) || (pl_s[1:0] != 2'd0)) begin
                err_r   <= 1'b1;
                state_r <= DRAIN;
              end else begin
                state_r <= OPND;
              end
            end
          end
        end
        ECHO: begin
          if (rx_fire_s) begin
            remain_r <= remain_dec_s;
            if (remain_r <= 16'd1) begin
              state_r <= IDLE;
            end
          end
        end
        OPND: begin
          if (rx_fire_s) begin
            remain_r   <= remain_dec_s;
            byte_cnt_r <= byte_cnt_r + 2'd1;
            operand_r[8*byte_cnt_r +: 8] <= rx_data_i;
            if (byte_cnt_r == 2'd3) begin
              ops_left_r <= ops_left_r - 14'd1;
              if (first_r) begin
                // The first operand seeds the accumulator without an ALU trip.
                first_r <= 1'b0;
                acc_r   <= word_s;
                if (ops_left_r == 14'd1) begin
                  tx_idx_r <= 2'd0;
                  state_r  <= TXRES;
                end
              end else begin
                state_r <= AREQ;
              end
            end
          end
        end
        AREQ: begin
          if (alu_ready_i) begin
            state_r <= AWAIT;
          end
        end
        AWAIT: begin
          if (alu_done_i) begin
            acc_r <= alu_result_i;
            if (ops_left_r != 14'd0) begin
              state_r <= OPND;
            end else begin
              tx_idx_r <= 2'd0;
              state_r  <= TXRES;
            end
          end
        end
        TXRES: begin
          if (tx_fire_s) begin
            tx_idx_r <= tx_idx_r + 2'd1;
            if (tx_idx_r == 2'd3) begin
              state_r <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (remain_r == 16'd0) begin
            state_r <= IDLE;
          end else if (rx_fire_s) begin
            remain_r <= remain_dec_s;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed plus randomized bench for uart_alu_sequencer with a packet-level reference model.
module tb_uart_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [1:0]  alu_op_o;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic        alu_valid_o;
  logic        alu_ready_i = 1'b0;
  logic        alu_done_i = 1'b0;
  logic [31:0] alu_result_i = 32'h0;
  logic        busy_o;
  logic        err_o;

  uart_alu_sequencer dut (
    .clk_i(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .alu_op_o(alu_op_o), .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_done_i(alu_done_i), .alu_result_i(alu_result_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int miss_cnt = 0;
  int tx_mode = 0;
  int alu_lat = 0;
  int err_seen = 0;
  int rdy_bad = 0;
  bit alu_busy = 1'b0;
  logic [7:0]  tx_log[$];
  logic [31:0] req_a[$];
  logic [31:0] req_b[$];
  logic [1:0]  req_op[$];
  logic [7:0]  pl_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miss_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX sink: readiness pattern selected by tx_mode, changed on the falling edge.
  always @(negedge clk) begin
    case (tx_mode)
      0:       tx_ready_i = 1'b1;
      1:       tx_ready_i = ~tx_ready_i;
      default: tx_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: records transfers that will complete at the coming rising edge.
  always begin
    @(negedge clk);
    #4;
    if (tx_valid_o === 1'b1 && tx_ready_i === 1'b1) tx_log.push_back(tx_data_o);
    if (err_o === 1'b1) err_seen++;
    if (alu_busy && rx_ready_o !== 1'b0) rdy_bad++;
  end

  // ALU model with configurable request and completion latency.
  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    forever begin
      @(negedge clk);
      if (alu_valid_o === 1'b1) begin
        alu_busy = 1'b1;
        repeat (alu_lat) @(negedge clk);
        ra = alu_a_o; rb = alu_b_o; rop = alu_op_o;
        req_a.push_back(ra); req_b.push_back(rb); req_op.push_back(rop);
        alu_ready_i = 1'b1;
        @(negedge clk);
        alu_ready_i = 1'b0;
        repeat (alu_lat) @(negedge clk);
        case (rop)
          2'd0:    alu_result_i = ra + rb;
          2'd1:    alu_result_i = ra - rb;
          2'd2:    alu_result_i = ra * rb;
          default: alu_result_i = 32'h0;
        endcase
        alu_done_i = 1'b1;
        @(negedge clk);
        alu_done_i = 1'b0;
        alu_busy = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    for (int k = 0; k < 2000 && !ok; k++) begin
      #4;
      ok = (rx_ready_o === 1'b1);
      @(negedge clk);
    end
    rx_valid_i = 1'b0;
    if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy_o !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", {31'd0, busy_o}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  // Sends opc/len/pl_q and compares TX bytes, ALU requests and err pulses with the model.
  task automatic run_packet(input string tag, input logic [7:0] opc, input logic [15:0] len);
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_a[$], exp_b[$];
    logic [1:0]  exp_op[$];
    logic [31:0] acc, w;
    logic [1:0]  code;
    bit arith, echo, bad;
    int err0, nw;
    arith = (opc == 8'h10) || (opc == 8'h11) || (opc == 8'h12);
    echo  = (opc == 8'hEC);
    bad   = (!arith && !echo) || (len < 16'd4) ||
            (arith && ((len == 16'd4) || (((int'(len) - 4) % 4) != 0)));
    code  = (opc == 8'h11) ? 2'd1 : (opc == 8'h12) ? 2'd2 : 2'd0;
    if (!bad && echo) exp_tx = pl_q;
    if (!bad && arith) begin
      nw = (int'(len) - 4) / 4;
      acc = 32'h0;
      for (int i = 0; i < nw; i++) begin
        w = {pl_q[4*i+3], pl_q[4*i+2], pl_q[4*i+1], pl_q[4*i]};
        if (i == 0) acc = w;
        else begin
          exp_a.push_back(acc); exp_b.push_back(w); exp_op.push_back(code);
          acc = (code == 2'd0) ? acc + w : (code == 2'd1) ? acc - w : acc * w;
        end
      end
      for (int i = 0; i < 4; i++) exp_tx.push_back(8'(acc >> (8 * i)));
    end
    tx_log.delete(); req_a.delete(); req_b.delete(); req_op.delete();
    err0 = err_seen;
    send_byte(opc);
    send_byte(8'($urandom_range(0, 255)));
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    wait_idle();
    chk({tag, "_err"}, 32'(err_seen - err0), {31'd0, bad});
    chk({tag, "_txlen"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
      chk({tag, "_txbyte"}, {24'd0, tx_log[i]}, {24'd0, exp_tx[i]});
    chk({tag, "_nreq"}, 32'(req_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < req_a.size(); i++) begin
      chk({tag, "_req_a"}, req_a[i], exp_a[i]);
      chk({tag, "_req_b"}, req_b[i], exp_b[i]);
      chk({tag, "_req_op"}, {30'd0, req_op[i]}, {30'd0, exp_op[i]});
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) pl_q.push_back(8'(w >> (8 * i)));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'd0, rx_ready_o}, 32'd0);
    chk({tag, "_tx_valid"}, {31'd0, tx_valid_o}, 32'd0);
    chk({tag, "_alu_valid"}, {31'd0, alu_valid_o}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
    chk({tag, "_tx_data"}, {24'd0, tx_data_o}, 32'd0);
    chk({tag, "_alu_ab"}, alu_a_o | alu_b_o, 32'd0);
    chk({tag, "_alu_op"}, {30'd0, alu_op_o}, 32'd0);
  endtask

  initial begin
    logic [7:0]  opc;
    logic [15:0] len;
    int kind, n, k;

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_i = 1'b0;
    repeat (2) @(negedge clk);

    tx_mode = 1;
    pl_q = '{8'h41, 8'h42, 8'h43};
    run_packet("echo3", 8'hEC, 16'd7);
    chk("echo3_busy_after", {31'd0, busy_o}, 32'd0);

    tx_mode = 0;
    pl_q.delete(); push_word(32'h0000_0001); push_word(32'hFFFF_FFFF);
    run_packet("add2", 8'h10, 16'd12);

    alu_lat = 5; rdy_bad = 0;
    pl_q.delete(); push_word(32'd10); push_word(32'd3); push_word(32'd2);
    run_packet("sub3", 8'h11, 16'd16);
    chk("sub3_rx_ready_while_alu", 32'(rdy_bad), 32'd0);
    alu_lat = 0;

    pl_q.delete(); push_word(32'h1234_5678);
    run_packet("mul1", 8'h12, 16'd8);

    pl_q = '{8'hAA, 8'hBB};
    run_packet("bad_opc", 8'h55, 16'd6);
    pl_q = '{8'h01, 8'h02, 8'h03};
    run_packet("bad_len", 8'h10, 16'd7);
    pl_q = '{8'h5A};
    run_packet("echo_after_err", 8'hEC, 16'd5);
    pl_q.delete();
    run_packet("echo_len4", 8'hEC, 16'd4);
    run_packet("short_len", 8'hEC, 16'd2);

    for (int p = 0; p < 24; p++) begin
      tx_mode = $urandom_range(0, 2);
      alu_lat = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      pl_q.delete();
      if (kind == 0) begin
        opc = 8'($urandom_range(0, 255));
        if (opc == 8'hEC || opc == 8'h10 || opc == 8'h11 || opc == 8'h12) opc = 8'h55;
        len = 16'($urandom_range(0, 9));
      end else if (kind == 1) begin
        opc = 8'h10 + 8'($urandom_range(0, 2));
        len = 16'd4 + 16'(4 * $urandom_range(0, 2)) + 16'($urandom_range(1, 3));
      end else if (kind < 4) begin
        opc = 8'hEC;
        len = 16'($urandom_range(4, 10));
      end else begin
        opc = 8'h10 + 8'($urandom_range(0, 2));
        len = 16'd4 + 16'(4 * $urandom_range(1, 4));
      end
      n = (len >= 16'd4) ? int'(len) - 4 : 0;
      for (int i = 0; i < n; i++) pl_q.push_back(8'($urandom_range(0, 255)));
      run_packet("rand", opc, len);
    end

    tx_mode = 0; alu_lat = 0;
    pl_q.delete(); push_word(32'd7); push_word(32'd8);
    tx_log.delete();
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h0C); send_byte(8'h00);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    k = 0;
    while (tx_log.size() < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("txres_two_bytes", 32'(tx_log.size()), 32'd2);
    rst_i = 1'b1;
    #1;
    check_reset_outputs("midtx_reset");
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("midtx_no_more_tx", 32'(tx_log.size()), 32'd2);
    run_packet("add_after_reset", 8'h10, 16'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
- Packet-level controller sitting between the UART RX/TX byte streams and the multi-cycle 32-bit ALU.
- Parses command packets from RX and either streams the payload back out TX (echo) or folds 32-bit operands through the ALU.
- Returns the 4-byte result on TX.
- Owns all sequencing of the ALU; the top level only wires byte streams and the ALU to it.

Parameters:
- OP_ECHO, 8'hEC, echo opcode
- OP_ADD, 8'h10, 32-bit add-reduce opcode
- OP_SUB, 8'h11, 32-bit subtract-reduce opcode
- OP_MUL, 8'h12, 32-bit multiply-reduce opcode (low 32 bits)

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous active-high reset; all state clears immediately
- rx_data_i  in  8  received byte
- rx_valid_i  in  1  rx_data_i valid
- rx_ready_o  out  1  sequencer accepts byte (transfer = valid & ready)
- tx_data_o  out  8  byte to transmit
- tx_valid_o  out  1  tx_data_o valid
- tx_ready_i  in  1  UART TX accepts byte
- alu_op_o  out  2  0=add, 1=sub, 2=mul
- alu_a_o  out  32  accumulator operand
- alu_b_o  out  32  new operand
- alu_valid_o  out  1  ALU request
- alu_ready_i  in  1  ALU accepts request (transfer = valid & ready)
- alu_done_i  in  1  one-cycle pulse, alu_result_i valid
- alu_result_i  in  32  ALU result
- busy_o  out  1  high in any state except IDLE
- err_o  out  1  one-cycle pulse on malformed packet

Behaviour:
- Packet format, byte order:
  - opcode
  - reserved (ignored)
  - length LSB
  - length MSB
  - payload
- Length is 16-bit, includes the 4 header bytes. Operands are little-endian 32-bit.
- Reset values: rx_ready_o=0, tx_valid_o=0, alu_valid_o=0, busy_o=0, err_o=0, all data outputs 0, state=IDLE. Reset mid-packet abandons the packet; no partial TX is completed.
- IDLE: rx_ready_o=1. Opcode transfer → HDR, header counter=1.
- HDR: rx_ready_o=1; captures reserved, len_lo, len_hi. After len_hi, the packet is validated:
  - Unknown opcode, or len<4 → DRAIN, err_o pulses on the len_hi-acceptance edge.
  - Echo with len=4 → IDLE.
  - Echo with len>4 → ECHO.
  - Arith with (len-4) not a nonzero multiple of 4 → DRAIN + err_o.
  - Otherwise → OPND; op count=(len-4)/4.
- Remaining-byte counter (16-bit) = len-4. Decrements on every accepted payload byte. Never wraps below 0.
- ECHO:
  - tx_data_o=rx_data_i, tx_valid_o=rx_valid_i, rx_ready_o=tx_ready_i (combinational pass-through, zero latency).
  - Counter hits 0 on last transfer → IDLE.
- OPND: rx_ready_o=1; assembles 4 bytes into operand register. On 4th byte:
  - First operand: load acc. If op count=1 → TXRES; else stay OPND.
  - Later operands → AREQ.
- AREQ: rx_ready_o=0; alu_valid_o=1 with alu_a_o=acc, alu_b_o=operand, alu_op_o per opcode. Hold all stable until alu_ready_i → AWAIT.
- AWAIT: alu_valid_o=0. On alu_done_i: acc=alu_result_i, then:
  - Operands remaining → OPND.
  - None remaining → TXRES.
  - A done pulse in any other state is ignored.
- TXRES: sends acc bytes [7:0],[15:8],[23:16],[31:24]. tx_valid_o held high, tx_data_o stable until tx_ready_i. 4th transfer → IDLE.
- DRAIN: rx_ready_o=1, no TX; discards len-4 bytes (0 if len<4) → IDLE.
- tx_valid_o never asserted outside ECHO/TXRES. alu_valid_o never asserted outside AREQ.
- Sub is acc-operand, left-fold. Mul keeps the low 32 bits. All arithmetic wraps modulo 2^32.
- rx_ready_o is low in AREQ/AWAIT/TXRES (backpressure); bytes wait upstream.

Test Plan:
- Echo EC 00 07 00 41 42 43 → TX 41 42 43 in order; tx_ready_i toggled every other cycle causes no loss or duplicate; busy_o falls after 43.
- Add 10 00 0C 00 + operands 0x00000001, 0xFFFFFFFF → one ALU request a=1, b=FFFFFFFF, op=0; ALU returns 0 → TX 00 00 00 00.
- Sub 11 00 10 00 + 10,3,2 (LE words) → two requests; TX 05 00 00 00; ALU with 5-cycle ready/done latency gives identical result, rx_ready_o=0 while waiting.
- Single operand 12 00 08 00 + 0x12345678 → no ALU request; TX 78 56 34 12.
- Malformed: opcode 0x55 len 6 then 2 bytes, and 10 00 07 00 + 3 bytes → err_o one pulse each, no TX, bytes drained; next echo packet works.
- Reset asserted mid-TXRES after 2 bytes → outputs to reset values same cycle; fresh add packet afterwards correct.
